// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the 5-stage pipeline sequencer.
// Holds the multi-cycle unit FSM state encoding, the forward-select codes and
// the default register-number width.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    // Operand source selects: register file, or bypass from EX / MEM / WB.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/pipe_mc_seq.sv
// pipe_mc_seq: handshake sequencer for the EX-stage multi-cycle unit (mul/div).
// Issues a start pulse when a valid multi-cycle op first sits in EX, waits for
// the unit's done pulse, then lets EX drain once MEM accepts. A flush aborts
// from any state and cancels the unit only if it was actually working.
module pipe_mc_seq
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic flush,
    input  logic es_valid,
    input  logic es_mc_op,
    input  logic mc_done,
    input  logic ms_allowin,
    output logic es_ready_go,
    output logic mc_start,
    output logic mc_cancel
);

    mc_state_t state_r;
    mc_state_t state_s;

    // FSM state register; reset puts the sequencer back to idle without a cancel.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r <= MC_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and pulse generation; a done pulse outside BUSY is ignored.
    always_comb begin
        state_s   = state_r;
        mc_start  = 1'b0;
        mc_cancel = 1'b0;
        if (flush) begin
            // The EX op is being killed: never start the unit on it, and abort a
            // computation that is still running.
            state_s   = MC_IDLE;
            mc_cancel = (state_r == MC_BUSY);
        end else begin
            case (state_r)
                MC_IDLE: begin
                    if (es_valid & es_mc_op) begin
                        state_s  = MC_BUSY;
                        mc_start = 1'b1;
                    end else begin
                        state_s = MC_IDLE;
                    end
                end
                MC_BUSY: begin
                    if (mc_done) begin
                        state_s = MC_DONE;
                    end else begin
                        state_s = MC_BUSY;
                    end
                end
                MC_DONE: begin
                    if (ms_allowin) begin
                        state_s = MC_IDLE;
                    end else begin
                        state_s = MC_DONE;
                    end
                end
                default: begin
                    state_s = MC_IDLE;
                end
            endcase
        end
    end

    // Single-cycle ops never hold EX; multi-cycle ops hold it until the result is in.
    assign es_ready_go = ~es_mc_op | (state_r == MC_DONE);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the IF/ID/EX/MEM/WB pipeline.
// Owns the per-stage valid bits, derives the allowin / load-enable handshakes
// for every inter-stage register, detects RAW hazards for the ID sources and
// sequences the EX multi-cycle unit through pipe_mc_seq.
// Build option: define PIPE_CTRL_FORWARD_EN to enable operand bypassing; then
// only a load in EX stalls a dependent ID instruction. Without it, ID waits
// until the producer has left WB (the register file has no write-through) and
// the forward selects are tied to the register file.
module pipe_ctrl #(
    parameter int REG_AW = pipe_ctrl_pkg::REG_AW,
    parameter int FWD_W  = 2
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              fs_valid,
    input  logic              flush,
    input  logic [REG_AW-1:0] ds_rs,
    input  logic [REG_AW-1:0] ds_rt,
    input  logic              ds_rs_used,
    input  logic              ds_rt_used,
    input  logic [REG_AW-1:0] es_dest,
    input  logic [REG_AW-1:0] ms_dest,
    input  logic [REG_AW-1:0] ws_dest,
    input  logic              es_we,
    input  logic              ms_we,
    input  logic              ws_we,
    input  logic              es_is_load,
    input  logic              es_mc_op,
    input  logic              mc_done,
    output logic              fs_allowin,
    output logic              ds_load,
    output logic              es_load,
    output logic              ms_load,
    output logic              ws_load,
    output logic              ds_valid_o,
    output logic              es_valid_o,
    output logic              ms_valid_o,
    output logic              ws_valid_o,
    output logic              mc_start,
    output logic              mc_cancel,
    output logic [FWD_W-1:0]  fwd_a_sel,
    output logic [FWD_W-1:0]  fwd_b_sel
);

    import pipe_ctrl_pkg::*;

    logic ds_valid_r;
    logic es_valid_r;
    logic ms_valid_r;
    logic ws_valid_r;

    logic ws_allowin_s;
    logic ms_allowin_s;
    logic es_allowin_s;
    logic ds_allowin_s;
    logic ds_ready_go_s;
    logic es_ready_go_s;
    logic hazard_s;

    logic rs_ex_s;
    logic rs_ms_s;
    logic rs_ws_s;
    logic rt_ex_s;
    logic rt_ms_s;
    logic rt_ws_s;

    // A source depends on a stage when that stage holds a live write to the
    // same register; r0 is hard-wired and never creates a dependency.
    function automatic logic src_hit(
        input logic [REG_AW-1:0] src,
        input logic              used,
        input logic [REG_AW-1:0] dest,
        input logic              vld,
        input logic              we
    );
        return vld & we & used & (dest == src) & (src != {REG_AW{1'b0}});
    endfunction

    assign rs_ex_s = src_hit(ds_rs, ds_rs_used, es_dest, es_valid_r, es_we);
    assign rs_ms_s = src_hit(ds_rs, ds_rs_used, ms_dest, ms_valid_r, ms_we);
    assign rs_ws_s = src_hit(ds_rs, ds_rs_used, ws_dest, ws_valid_r, ws_we);
    assign rt_ex_s = src_hit(ds_rt, ds_rt_used, es_dest, es_valid_r, es_we);
    assign rt_ms_s = src_hit(ds_rt, ds_rt_used, ms_dest, ms_valid_r, ms_we);
    assign rt_ws_s = src_hit(ds_rt, ds_rt_used, ws_dest, ws_valid_r, ws_we);

`ifdef PIPE_CTRL_FORWARD_EN
    // Only a load in EX has no value to bypass yet.
    assign hazard_s = (rs_ex_s | rt_ex_s) & es_is_load;

    // Bypass selection, youngest producer first (EX, then MEM, then WB).
    always_comb begin
        fwd_a_sel = FWD_W'(FWD_RF);
        fwd_b_sel = FWD_W'(FWD_RF);
        if (rs_ex_s) begin
            fwd_a_sel = FWD_W'(FWD_EX);
        end else if (rs_ms_s) begin
            fwd_a_sel = FWD_W'(FWD_MEM);
        end else if (rs_ws_s) begin
            fwd_a_sel = FWD_W'(FWD_WB);
        end else begin
            fwd_a_sel = FWD_W'(FWD_RF);
        end
        if (rt_ex_s) begin
            fwd_b_sel = FWD_W'(FWD_EX);
        end else if (rt_ms_s) begin
            fwd_b_sel = FWD_W'(FWD_MEM);
        end else if (rt_ws_s) begin
            fwd_b_sel = FWD_W'(FWD_WB);
        end else begin
            fwd_b_sel = FWD_W'(FWD_RF);
        end
    end
`else
    logic unused_s;

    // Without bypassing, any in-flight producer blocks ID; load-ness is irrelevant.
    assign hazard_s  = rs_ex_s | rt_ex_s | rs_ms_s | rt_ms_s | rs_ws_s | rt_ws_s;
    assign unused_s  = es_is_load;
    assign fwd_a_sel = FWD_W'(FWD_RF);
    assign fwd_b_sel = FWD_W'(FWD_RF);
`endif

    assign ds_ready_go_s = ~hazard_s;

    // Backpressure chain, WB always accepts.
    assign ws_allowin_s = 1'b1;
    assign ms_allowin_s = ~ms_valid_r | ws_allowin_s;
    assign es_allowin_s = ~es_valid_r | (es_ready_go_s & ms_allowin_s);
    assign ds_allowin_s = ~ds_valid_r | (ds_ready_go_s & es_allowin_s);
    assign fs_allowin   = ds_allowin_s;

    assign ds_load = ds_allowin_s & fs_valid;
    assign es_load = es_allowin_s & ds_valid_r & ds_ready_go_s;
    assign ms_load = ms_allowin_s & es_valid_r & es_ready_go_s;
    assign ws_load = ms_valid_r;

    // Stage valid bits; flush kills ID and EX only, MEM/WB keep retiring.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            ds_valid_r <= 1'b0;
            es_valid_r <= 1'b0;
            ms_valid_r <= 1'b0;
            ws_valid_r <= 1'b0;
        end else begin
            if (flush) begin
                ds_valid_r <= 1'b0;
            end else if (ds_allowin_s) begin
                ds_valid_r <= fs_valid;
            end else begin
                ds_valid_r <= ds_valid_r;
            end
            if (flush) begin
                es_valid_r <= 1'b0;
            end else if (es_allowin_s) begin
                es_valid_r <= ds_valid_r & ds_ready_go_s;
            end else begin
                es_valid_r <= es_valid_r;
            end
            if (ms_allowin_s) begin
                ms_valid_r <= es_valid_r & es_ready_go_s;
            end else begin
                ms_valid_r <= ms_valid_r;
            end
            ws_valid_r <= ms_valid_r;
        end
    end

    assign ds_valid_o = ds_valid_r;
    assign es_valid_o = es_valid_r;
    assign ms_valid_o = ms_valid_r;
    assign ws_valid_o = ws_valid_r;

    pipe_mc_seq u_mc_seq (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .es_valid    (es_valid_r),
        .es_mc_op    (es_mc_op),
        .mc_done     (mc_done),
        .ms_allowin  (ms_allowin_s),
        .es_ready_go (es_ready_go_s),
        .mc_start    (mc_start),
        .mc_cancel   (mc_cancel)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl.
// Each step drives the inputs for one cycle, pushes the hand-derived expected
// output vector, and pops/compares it against the DUT on the falling edge.
// Vector layout: {ds,es,ms,ws valid, fs_allowin, ds/es/ms/ws load,
//                 mc_start, mc_cancel, fwd_a_sel, fwd_b_sel}.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       fs_valid;
    logic       flush;
    logic [4:0] ds_rs;
    logic [4:0] ds_rt;
    logic       ds_rs_used;
    logic       ds_rt_used;
    logic [4:0] es_dest;
    logic [4:0] ms_dest;
    logic [4:0] ws_dest;
    logic       es_we;
    logic       ms_we;
    logic       ws_we;
    logic       es_is_load;
    logic       es_mc_op;
    logic       mc_done;
    logic       fs_allowin;
    logic       ds_load;
    logic       es_load;
    logic       ms_load;
    logic       ws_load;
    logic       ds_valid_o;
    logic       es_valid_o;
    logic       ms_valid_o;
    logic       ws_valid_o;
    logic       mc_start;
    logic       mc_cancel;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    typedef struct {
        string       tag;
        logic [14:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [14:0] obs;

    pipe_ctrl #(.REG_AW(5), .FWD_W(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fs_valid   (fs_valid),
        .flush      (flush),
        .ds_rs      (ds_rs),
        .ds_rt      (ds_rt),
        .ds_rs_used (ds_rs_used),
        .ds_rt_used (ds_rt_used),
        .es_dest    (es_dest),
        .ms_dest    (ms_dest),
        .ws_dest    (ws_dest),
        .es_we      (es_we),
        .ms_we      (ms_we),
        .ws_we      (ws_we),
        .es_is_load (es_is_load),
        .es_mc_op   (es_mc_op),
        .mc_done    (mc_done),
        .fs_allowin (fs_allowin),
        .ds_load    (ds_load),
        .es_load    (es_load),
        .ms_load    (ms_load),
        .ws_load    (ws_load),
        .ds_valid_o (ds_valid_o),
        .es_valid_o (es_valid_o),
        .ms_valid_o (ms_valid_o),
        .ws_valid_o (ws_valid_o),
        .mc_start   (mc_start),
        .mc_cancel  (mc_cancel),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel)
    );

    always #5 clk = ~clk;

    assign obs = {ds_valid_o, es_valid_o, ms_valid_o, ws_valid_o,
                  fs_allowin, ds_load, es_load, ms_load, ws_load,
                  mc_start, mc_cancel, fwd_a_sel, fwd_b_sel};

    // v = {ds,es,ms,ws valid}; ld = {fs_allowin,ds,es,ms,ws load}; pc = {start,cancel}
    function automatic logic [14:0] ev(input logic [3:0] v, input logic [4:0] ld,
                                       input logic [1:0] pc, input logic [1:0] fa,
                                       input logic [1:0] fb);
        return {v, ld, pc, fa, fb};
    endfunction

    task automatic step(input string tag, input logic [14:0] exp);
        sb_t e;
        sb_q.push_back('{tag, exp});
        @(negedge clk);
        e = sb_q.pop_front();
        n_chk++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b1; fs_valid = 1'b0; flush = 1'b0;
        ds_rs = 5'd0; ds_rt = 5'd0; ds_rs_used = 1'b0; ds_rt_used = 1'b0;
        es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0;
        es_we = 1'b0; ms_we = 1'b0; ws_we = 1'b0;
        es_is_load = 1'b0; es_mc_op = 1'b0; mc_done = 1'b0;

        step("reset", ev(4'b0000, 5'b10000, 2'b00, 2'd0, 2'd0));

        // Pipeline fill with a constant instruction stream.
        resetn = 1'b0; fs_valid = 1'b1;
        step("fill0", ev(4'b0000, 5'b11000, 2'b00, 2'd0, 2'd0));
        step("fill1", ev(4'b1000, 5'b11100, 2'b00, 2'd0, 2'd0));
        step("fill2", ev(4'b1100, 5'b11110, 2'b00, 2'd0, 2'd0));
        step("fill3", ev(4'b1110, 5'b11111, 2'b00, 2'd0, 2'd0));
        step("fill4", ev(4'b1111, 5'b11111, 2'b00, 2'd0, 2'd0));
        step("fill5", ev(4'b1111, 5'b11111, 2'b00, 2'd0, 2'd0));

`ifdef PIPE_CTRL_FORWARD_EN
        es_we = 1'b1; es_dest = 5'd8; es_is_load = 1'b1; ds_rs = 5'd8; ds_rs_used = 1'b1;
        step("load_use", ev(4'b1111, 5'b00011, 2'b00, 2'd1, 2'd0));
        es_we = 1'b0; es_is_load = 1'b0; ms_we = 1'b1; ms_dest = 5'd8;
        step("fwd_mem", ev(4'b1011, 5'b11101, 2'b00, 2'd2, 2'd0));
        ms_we = 1'b0; ds_rs_used = 1'b0;
        step("bubble_drain", ev(4'b1101, 5'b11110, 2'b00, 2'd0, 2'd0));
        es_we = 1'b1; es_dest = 5'd3; ms_we = 1'b1; ms_dest = 5'd3; ds_rs = 5'd3; ds_rs_used = 1'b1;
        step("fwd_prio_ex", ev(4'b1110, 5'b11111, 2'b00, 2'd1, 2'd0));
        es_we = 1'b0; ws_we = 1'b1; ws_dest = 5'd4; ds_rt = 5'd4; ds_rt_used = 1'b1;
        step("fwd_mem_wb", ev(4'b1111, 5'b11111, 2'b00, 2'd2, 2'd3));
`else
        es_we = 1'b1; es_dest = 5'd5; ds_rt = 5'd5; ds_rt_used = 1'b1;
        step("raw_ex", ev(4'b1111, 5'b00011, 2'b00, 2'd0, 2'd0));
        es_we = 1'b0; ms_we = 1'b1; ms_dest = 5'd5;
        step("raw_mem", ev(4'b1011, 5'b00001, 2'b00, 2'd0, 2'd0));
        ms_we = 1'b0; ws_we = 1'b1; ws_dest = 5'd5;
        step("raw_wb", ev(4'b1001, 5'b00000, 2'b00, 2'd0, 2'd0));
        ws_we = 1'b0;
        step("raw_release", ev(4'b1000, 5'b11100, 2'b00, 2'd0, 2'd0));
        es_we = 1'b1; es_dest = 5'd0; ds_rt = 5'd0;
        step("zero_reg", ev(4'b1100, 5'b11110, 2'b00, 2'd0, 2'd0));
        es_dest = 5'd7; ds_rs = 5'd7; ds_rs_used = 1'b0;
        step("unused_src", ev(4'b1110, 5'b11111, 2'b00, 2'd0, 2'd0));
`endif
        es_we = 1'b0; ms_we = 1'b0; ws_we = 1'b0; es_dest = 5'd0; ms_dest = 5'd0; ws_dest = 5'd0;
        ds_rs = 5'd0; ds_rt = 5'd0; ds_rs_used = 1'b0; ds_rt_used = 1'b0;

        // Multi-cycle op in EX, done arrives six cycles after start.
        es_mc_op = 1'b1;
        step("mc_start", ev(4'b1111, 5'b00001, 2'b10, 2'd0, 2'd0));
        step("mc_busy1", ev(4'b1101, 5'b00000, 2'b00, 2'd0, 2'd0));
        for (int i = 0; i < 4; i++) begin
            step("mc_busy", ev(4'b1100, 5'b00000, 2'b00, 2'd0, 2'd0));
        end
        mc_done = 1'b1;
        step("mc_done_cyc", ev(4'b1100, 5'b00000, 2'b00, 2'd0, 2'd0));
        mc_done = 1'b0;
        step("mc_exit", ev(4'b1100, 5'b11110, 2'b00, 2'd0, 2'd0));
        es_mc_op = 1'b0; mc_done = 1'b1;
        step("mc_done_idle", ev(4'b1110, 5'b11111, 2'b00, 2'd0, 2'd0));

        // Flush while the unit is busy, then a late done that must be ignored.
        es_mc_op = 1'b1; mc_done = 1'b0;
        step("mc_start2", ev(4'b1111, 5'b00001, 2'b10, 2'd0, 2'd0));
        flush = 1'b1;
        step("flush_cancel", ev(4'b1101, 5'b00000, 2'b01, 2'd0, 2'd0));
        flush = 1'b0; mc_done = 1'b1;
        step("flush_clear", ev(4'b0000, 5'b11000, 2'b00, 2'd0, 2'd0));
        mc_done = 1'b0; es_mc_op = 1'b0;
        step("refill", ev(4'b1000, 5'b11100, 2'b00, 2'd0, 2'd0));
        es_mc_op = 1'b1;
        step("idle_after_flush", ev(4'b1100, 5'b00000, 2'b10, 2'd0, 2'd0));
        mc_done = 1'b1;
        step("busy_done", ev(4'b1100, 5'b00000, 2'b00, 2'd0, 2'd0));
        mc_done = 1'b0;
        step("exit2", ev(4'b1100, 5'b11110, 2'b00, 2'd0, 2'd0));
        step("mc_start3", ev(4'b1110, 5'b00001, 2'b10, 2'd0, 2'd0));

        // Reset while busy: everything clears and no cancel is issued.
        resetn = 1'b1; fs_valid = 1'b0; flush = 1'b1;
        step("reset_busy", ev(4'b0000, 5'b10000, 2'b00, 2'd0, 2'd0));
        resetn = 1'b0; flush = 1'b0; es_mc_op = 1'b0;
        step("post_reset", ev(4'b0000, 5'b10000, 2'b00, 2'd0, 2'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the 5-stage MIPS core (IF/ID/EX/MEM/WB). Holds per-stage valid bits, produces allowin/load-enable handshakes for every inter-stage register, detects RAW hazards between ID sources and in-flight destinations, and drives the EX multi-cycle unit (mul/div) start/done/cancel handshake. All stage datapath registers load only when this block says so.

## Interface
Parameters:
- REG_AW, 5, register-number width
- FWD_W, 2, forward-select width

Ports (reset resetn, asynchronous, active-high; clock clk):
- clk  in  1  clock
- resetn  in  1  async reset, active-high
- fs_valid  in  1  IF presents a fetched instruction
- flush  in  1  kill ID and EX contents at next edge
- ds_rs, ds_rt  in  REG_AW  ID source registers
- ds_rs_used, ds_rt_used  in  1  source actually read
- es_dest, ms_dest, ws_dest  in  REG_AW  stage destination registers
- es_we, ms_we, ws_we  in  1  stage writes regfile
- es_is_load  in  1  EX instruction is a load
- es_mc_op  in  1  EX instruction is multi-cycle
- mc_done  in  1  multi-cycle unit result ready (pulse)
- fs_allowin  out  1  IF may advance PC
- ds_load, es_load, ms_load, ws_load  out  1  load enables for IF/ID, ID/EX, EX/MEM, MEM/WB registers
- ds_valid_o, es_valid_o, ms_valid_o, ws_valid_o  out  1  stage valid bits
- mc_start, mc_cancel  out  1  one-cycle pulses to multi-cycle unit
- fwd_a_sel, fwd_b_sel  out  FWD_W  0 regfile, 1 EX, 2 MEM, 3 WB

## Operation
- Handshake: ws_allowin=1; ms_allowin=!ms_valid|ws_allowin; es_allowin=!es_valid|(es_ready_go&ms_allowin); ds_allowin=!ds_valid|(ds_ready_go&es_allowin); fs_allowin=ds_allowin.
- Valids: ds_valid<=flush?0:(ds_allowin?fs_valid:ds_valid); es_valid<=flush?0:(es_allowin?ds_valid&ds_ready_go:es_valid); ms_valid<=ms_allowin?es_valid&es_ready_go:ms_valid; ws_valid<=ms_valid.
- Loads: ds_load=ds_allowin&fs_valid; es_load=es_allowin&ds_valid&ds_ready_go; ms_load=ms_allowin&es_valid&es_ready_go; ws_load=ms_valid.
- Match(src,stage)=stage_valid&stage_we&(stage_dest==src)&(src!=0)&src_used.
- ds_ready_go=!hazard; ms_ready_go=1.
- Forward priority EX>MEM>WB; sel=0 when no match.
- Multi-cycle FSM (MC_IDLE, MC_BUSY, MC_DONE): IDLE&es_valid&es_mc_op -> mc_start, go BUSY; BUSY&mc_done -> DONE; DONE&ms_allowin -> IDLE. es_ready_go=!es_mc_op|(state==MC_DONE). mc_done outside BUSY ignored.
- flush: FSM -> IDLE from any state; mc_cancel pulses if state was BUSY. flush does not touch ms/ws.

## Timing
- Reset: all valids 0, FSM MC_IDLE, all load/pulse outputs 0, fwd sels 0, fs_allowin 1 (combinational from cleared valids).
- Handshake outputs combinational from current state and inputs; valids/FSM registered.
- mc_start asserted the first cycle EX holds a valid mc op; earliest EX exit is the cycle after mc_done.
- A stalled ID re-evaluates every cycle; stall releases the cycle the producer leaves the matching stage.
- flush with fs_valid same cycle: ds_valid <= 0 (flush wins).
- Reset mid-BUSY: FSM to IDLE, no mc_cancel.

## Configuration
- PIPE_CTRL_FORWARD_EN defined: hazard = any source matches EX with es_is_load; fwd sels active.
- Undefined: hazard = any source matches EX, MEM or WB (regfile has no write-through); fwd_a_sel/fwd_b_sel tied 0.

## Structure
- pipe_ctrl_pkg: MC state enum (MC_IDLE, MC_BUSY, MC_DONE), FWD_RF/FWD_EX/FWD_MEM/FWD_WB constants, REG_AW.
- Sub-module pipe_mc_seq: multi-cycle FSM producing es_ready_go, mc_start, mc_cancel.

## Test plan
- Reset, fs_valid=1 constant, no hazards -> ds/es/ms/ws_valid rise on consecutive cycles 1..4; all load enables 1 steady.
- (FORWARD_EN) EX load dest=8, ID rs=8 used -> 1-cycle stall (ds_load=0, es bubble), then fwd_a_sel=2.
- (no FORWARD_EN) EX add dest=5, ID rt=5 -> ID stalls 3 cycles; rt=0 with dest=0 -> no stall.
- es_mc_op, mc_done 6 cycles after mc_start -> mc_start one pulse, EX held 7 cycles, MEM bubbles meanwhile.
- flush during MC_BUSY -> mc_cancel pulse, es_valid/ds_valid 0 next cycle, FSM IDLE, late mc_done ignored.
- EX dest=3 and MEM dest=3, ID rs=3 (FORWARD_EN) -> fwd_a_sel=1.
